// File: rtl/std_mem_d1_stream_writer_if.sv
// Valid/ready word stream feeding std_mem_d1_stream_writer.
// master = word producer, slave = the writer consuming words.
interface std_mem_d1_stream_writer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/std_mem_d1_stream_writer.sv
// Fill engine for std_mem_d1: writes a valid/ready word stream to addresses 0..n-1,
// one memory write per word, waiting on the memory's done between writes.
module std_mem_d1_stream_writer #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [IDX_SIZE:0]   len,
    std_mem_d1_stream_writer_if.slave in_s,
    output logic [IDX_SIZE-1:0] mem_addr0,
    output logic [WIDTH-1:0]    mem_write_data,
    output logic                mem_write_en,
    input  logic                mem_done,
    output logic [IDX_SIZE:0]   count,
    output logic                done
);

    typedef enum logic [2:0] {StIdle, StAccept, StWrite, StWait, StDone} state_e;

    localparam logic [IDX_SIZE:0]   SizeW  = (IDX_SIZE + 1)'(SIZE);
    localparam logic [IDX_SIZE:0]   CntOne = 1;
    localparam logic [IDX_SIZE-1:0] IdxOne = 1;

    state_e              state;
    logic [IDX_SIZE:0]   n;
    logic [IDX_SIZE-1:0] idx;
    logic                in_ready;
    logic [IDX_SIZE:0]   len_clamped;
    logic                last;

    // Oversized requests are clamped so addresses never wrap past the memory.
    assign len_clamped   = (len > SizeW) ? SizeW : len;
    assign last          = ({1'b0, idx} == (n - CntOne));
    assign in_s.in_ready = in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= StIdle;
            n              <= '0;
            idx            <= '0;
            count          <= '0;
            mem_addr0      <= '0;
            mem_write_data <= '0;
            mem_write_en   <= 1'b0;
            in_ready       <= 1'b0;
            done           <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (go) begin
                        n     <= len_clamped;
                        idx   <= '0;
                        count <= '0;
                        if (len_clamped == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state    <= StAccept;
                            in_ready <= 1'b1;
                        end
                    end
                end
                StAccept: begin
                    if (in_s.in_valid) begin
                        mem_write_data <= in_s.in_data;
                        mem_addr0      <= idx;
                        in_ready       <= 1'b0;
                        mem_write_en   <= 1'b1;
                        state          <= StWrite;
                    end
                end
                StWrite: begin
                    mem_write_en <= 1'b0;
                    state        <= StWait;
                end
                StWait: begin
                    // Hold here for as long as the memory takes to acknowledge.
                    if (mem_done) begin
                        count <= count + CntOne;
                        if (last) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            idx      <= idx + IdxOne;
                            state    <= StAccept;
                            in_ready <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_std_mem_d1_stream_writer.sv
// Self-checking bench for std_mem_d1_stream_writer with a latency-programmable memory model.
module tb_std_mem_d1_stream_writer;
    localparam int WIDTH = 32;
    localparam int SIZE  = 16;
    localparam int IDX   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             go = 1'b0;
    logic [IDX:0]     len = '0;
    logic [IDX-1:0]   mem_addr0;
    logic [WIDTH-1:0] mem_write_data;
    logic             mem_write_en;
    logic             mem_done;
    logic [IDX:0]     count;
    logic             done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] mem_arr [SIZE];
    logic [WIDTH-1:0] sent[$];
    int               mem_lat = 0;
    logic             busy;
    int               wait_cnt;

    std_mem_d1_stream_writer_if #(.WIDTH(WIDTH)) s_if ();

    std_mem_d1_stream_writer #(
        .WIDTH   (WIDTH),
        .SIZE    (SIZE),
        .IDX_SIZE(IDX)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .go            (go),
        .len           (len),
        .in_s          (s_if),
        .mem_addr0     (mem_addr0),
        .mem_write_data(mem_write_data),
        .mem_write_en  (mem_write_en),
        .mem_done      (mem_done),
        .count         (count),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Memory: done arrives mem_lat cycles later than a plain std_mem_d1 would give it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_done <= 1'b0;
            busy     <= 1'b0;
            wait_cnt <= 0;
        end else begin
            mem_done <= 1'b0;
            if (mem_write_en) begin
                mem_arr[mem_addr0] <= mem_write_data;
                if (mem_lat == 0) mem_done <= 1'b1;
                else begin
                    busy     <= 1'b1;
                    wait_cnt <= mem_lat - 1;
                end
            end else if (busy) begin
                if (wait_cnt == 0) begin
                    mem_done <= 1'b1;
                    busy     <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle (counted from the go cycle = 0) of the next handshake the stream permits.
    function automatic int exp_hs(input int prev, input bit first, input int lat,
                                  input logic [3:0] vm);
        int r;
        r = first ? 1 : prev + 3 + lat;
        while (!vm[r % 4]) r++;
        return r;
    endfunction

    task automatic run_fill(input int len_in, input logic [3:0] vm, input int lat,
                            input int go_at, input string nm);
        int               n;
        int               c;
        int               e;
        int               viol;
        int               hs[$];
        int               wr[$];
        int               dn[$];
        logic [IDX-1:0]   wa[$];
        logic [WIDTH-1:0] wd[$];
        n = (len_in > SIZE) ? SIZE : len_in;
        sent.delete();
        mem_lat = lat;
        viol = 0;
        go = 1'b1;
        len = (IDX + 1)'(len_in);
        s_if.in_valid = 1'b0;
        step();
        go = 1'b0;
        c = 1;
        while (c < 400) begin
            go = (c == go_at);
            len = go ? (IDX + 1)'(1) : (IDX + 1)'($urandom);
            s_if.in_valid = vm[c % 4];
            s_if.in_data = $urandom;
            #1;
            if (s_if.in_ready && s_if.in_valid) begin
                hs.push_back(c);
                sent.push_back(s_if.in_data);
            end
            if (mem_write_en) begin
                wr.push_back(c);
                wa.push_back(mem_addr0);
                wd.push_back(mem_write_data);
            end
            if (mem_write_en && s_if.in_ready) viol++;
            if (done) dn.push_back(c);
            step();
            c++;
            if (dn.size() > 0 && c > dn[0] + 2) break;
        end
        go = 1'b0;
        s_if.in_valid = 1'b0;
        chk({nm, " done pulses"}, dn.size(), 1);
        chk({nm, " handshakes"}, hs.size(), n);
        chk({nm, " writes"}, wr.size(), n);
        chk({nm, " ready during write"}, viol, 0);
        e = 0;
        for (int i = 0; i < n && i < hs.size(); i++) begin
            e = exp_hs(e, i == 0, lat, vm);
            chk({nm, " handshake cycle"}, hs[i], e);
        end
        for (int i = 0; i < n && i < wr.size() && i < sent.size(); i++) begin
            chk({nm, " write addr"}, wa[i], i);
            chk({nm, " write data"}, wd[i], sent[i]);
            chk({nm, " write cycle"}, wr[i], hs[i] + 1);
            chk({nm, " mem readback"}, mem_arr[i], sent[i]);
        end
        if (dn.size() > 0) chk({nm, " done cycle"}, dn[0], (n == 0) ? 1 : e + 3 + lat);
        chk({nm, " count held"}, count, n);
        chk({nm, " idle ready"}, s_if.in_ready, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] saved[$];
        int               c;
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset in_ready", s_if.in_ready, 0);
        chk("reset write_en", mem_write_en, 0);
        chk("reset done", done, 0);
        chk("reset count", count, 0);
        #9 rst_n = 1'b1;
        step();

        run_fill(4, 4'b1111, 0, -1, "fill4");
        run_fill(3, 4'b1001, 0, -1, "gaps");
        run_fill(0, 4'b1111, 0, -1, "len0");
        run_fill(20, 4'b1111, 0, -1, "len20");
        run_fill(3, 4'b1111, 5, -1, "slowmem");
        run_fill(5, 4'b1111, 0, 4, "go_busy");

        // Reset in the middle of an 8-word fill, right after the 3rd word commits.
        mem_lat = 0;
        go = 1'b1;
        len = 5'd8;
        step();
        go = 1'b0;
        s_if.in_valid = 1'b1;
        c = 0;
        while (count != 5'd3 && c < 100) begin
            s_if.in_data = $urandom;
            #1;
            if (s_if.in_ready && s_if.in_valid) saved.push_back(s_if.in_data);
            step();
            c++;
        end
        chk("midrst reached 3 words", c < 100, 1);
        chk("midrst handshakes", saved.size(), 3);
        s_if.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst in_ready", s_if.in_ready, 0);
        chk("midrst write_en", mem_write_en, 0);
        chk("midrst done", done, 0);
        chk("midrst count", count, 0);
        chk("midrst addr", mem_addr0, 0);
        chk("midrst wdata", mem_write_data, 0);
        for (int i = 0; i < 3 && i < saved.size(); i++) chk("midrst retained", mem_arr[i], saved[i]);
        #2 rst_n = 1'b1;
        step();
        run_fill(2, 4'b1111, 0, -1, "after_rst");
        if (saved.size() == 3) chk("after_rst word2 kept", mem_arr[2], saved[2]);

        for (int k = 0; k < 3; k++) begin
            run_fill($urandom_range(1, 18), 4'($urandom_range(1, 15)), $urandom_range(0, 3), -1,
                     "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
